// File: rtl/mesh_port_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ local packet sources into one
// mesh router terminal input port. It holds one packet toward the router
// and reloads on the same edge the router pops, so back-to-back transfers
// have no idle cycle between them.
module mesh_port_arbiter #(
  parameter int unsigned PAKG_SIZE = 32,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              en_i,
  input  logic [NUM_REQ-1:0]                req_pndng_i,
  input  logic [NUM_REQ*PAKG_SIZE-1:0]      req_data_i,
  output logic [NUM_REQ-1:0]                req_pop_o,
  output logic                              pndng_o,
  output logic [PAKG_SIZE-1:0]              data_out_o,
  input  logic                              popin_i,
  output logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0] grant_id_o,
  output logic [CNT_W-1:0]                  sent_cnt_o
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [ID_W-1:0]      rr_ptr_q;
  logic [ID_W-1:0]      sel_id;
  logic [ID_W:0]        scan_idx;
  logic                 sel_any;
  logic [NUM_REQ-1:0]   sel_onehot;
  logic [PAKG_SIZE-1:0] sel_pkt;
  logic [ID_W-1:0]      next_ptr;
  logic                 grant;
  logic                 accept;

  // Find the first pending requester at or after rr_ptr, wrapping around.
  always_comb begin
    sel_any  = 1'b0;
    sel_id   = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = (ID_W+1)'(rr_ptr_q) + (ID_W+1)'(i);
      if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
      end
      if (!sel_any && req_pndng_i[scan_idx[ID_W-1:0]]) begin
        sel_any = 1'b1;
        sel_id  = scan_idx[ID_W-1:0];
      end
    end
  end

  // Decode the winner into a one-hot pop vector and pick its head packet.
  always_comb begin
    sel_onehot = '0;
    sel_pkt    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (sel_id == ID_W'(k)) begin
        sel_onehot[k] = 1'b1;
        sel_pkt       = req_data_i[k*PAKG_SIZE +: PAKG_SIZE];
      end
    end
  end

  // Router accepting the held packet, and a new grant (which may coincide).
  always_comb begin
    accept   = (state_q == HOLD) && popin_i;
    grant    = rst_i && en_i && sel_any && ((state_q == IDLE) || popin_i);
    next_ptr = (sel_id == ID_W'(NUM_REQ - 1)) ? '0 : sel_id + ID_W'(1);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: enter or stay in HOLD whenever a grant happens.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant) state_d = HOLD;
      end
      HOLD: begin
        if (popin_i) state_d = grant ? HOLD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: pending flag follows the state, pop pulses only on a grant.
  always_comb begin
    pndng_o   = 1'b0;
    req_pop_o = '0;
    if (state_q == HOLD) pndng_o = 1'b1;
    if (grant) req_pop_o = sel_onehot;
  end

  // Presented packet, its source id, round-robin pointer and sent counter.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      data_out_o <= '0;
      grant_id_o <= '0;
      rr_ptr_q   <= '0;
      sent_cnt_o <= '0;
    end else begin
      if (grant) begin
        data_out_o <= sel_pkt;
        grant_id_o <= sel_id;
        rr_ptr_q   <= next_ptr;
      end
      if (accept) begin
        sent_cnt_o <= sent_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mesh_port_arbiter.sv
// Bench for mesh_port_arbiter: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// transaction-level model of the port.
module tb_mesh_port_arbiter;

  localparam int unsigned PW = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned CW = 4;

  logic           clk;
  logic           rst_i;
  logic           en_i;
  logic [NR-1:0]  req_pndng_i;
  logic [NR*PW-1:0] req_data_i;
  logic [NR-1:0]  req_pop_o;
  logic           pndng_o;
  logic [PW-1:0]  data_out_o;
  logic           popin_i;
  logic [1:0]     grant_id_o;
  logic [CW-1:0]  sent_cnt_o;

  int total = 0;
  int bad   = 0;

  // Model of what the router port must show.
  bit        m_hold;
  logic [31:0] m_data;
  int        m_gid;
  int        m_ptr;
  int        m_cnt;

  mesh_port_arbiter #(.PAKG_SIZE(PW), .NUM_REQ(NR), .CNT_W(CW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .req_pndng_i (req_pndng_i),
    .req_data_i  (req_data_i),
    .req_pop_o   (req_pop_o),
    .pndng_o     (pndng_o),
    .data_out_o  (data_out_o),
    .popin_i     (popin_i),
    .grant_id_o  (grant_id_o),
    .sent_cnt_o  (sent_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] head(input int k);
    logic [NR*PW-1:0] d;
    d = req_data_i;
    return d[k*PW +: PW];
  endfunction

  task automatic model_reset();
    m_hold = 1'b0;
    m_data = '0;
    m_gid  = 0;
    m_ptr  = 0;
    m_cnt  = 0;
  endtask

  // One clock: inputs already driven after the falling edge. Compare the
  // DUT against the model, then advance the model across the rising edge.
  task automatic step();
    logic [NR-1:0] e_pop;
    bit            found;
    int            sel;
    #1;
    found = 1'b0;
    sel   = 0;
    for (int i = 0; i < int'(NR); i++) begin
      int k;
      k = (m_ptr + i) % int'(NR);
      if (!found && req_pndng_i[k]) begin
        found = 1'b1;
        sel   = k;
      end
    end
    e_pop = '0;
    if (rst_i && en_i && found && (!m_hold || popin_i)) e_pop = NR'(1) << sel;
    chk("req_pop", 32'(req_pop_o), 32'(e_pop));
    chk("pndng", 32'(pndng_o), 32'(m_hold));
    chk("data_out", data_out_o, m_data);
    chk("grant_id", 32'(grant_id_o), 32'(m_gid));
    chk("sent_cnt", 32'(sent_cnt_o), 32'(m_cnt));
    @(posedge clk);
    if (!rst_i) begin
      model_reset();
    end else begin
      if (m_hold && popin_i) m_cnt = (m_cnt + 1) % (1 << CW);
      if (e_pop != '0) begin
        m_hold = 1'b1;
        m_data = head(sel);
        m_gid  = sel;
        m_ptr  = (sel + 1) % int'(NR);
      end else if (m_hold && popin_i) begin
        m_hold = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_i       = 1'b0;
    en_i        = 1'b0;
    popin_i     = 1'b0;
    req_pndng_i = '0;
    req_data_i  = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("rst_pndng", 32'(pndng_o), 32'd0);
    chk("rst_data", data_out_o, 32'd0);
    chk("rst_gid", 32'(grant_id_o), 32'd0);
    chk("rst_cnt", 32'(sent_cnt_o), 32'd0);
    chk("rst_pop", 32'(req_pop_o), 32'd0);

    // Single request granted in the first cycle out of reset.
    rst_i = 1'b1; en_i = 1'b1; req_pndng_i = 4'b0100;
    #1 chk("single_pop", 32'(req_pop_o), 32'h4);
    step();
    req_pndng_i = 4'b0000;
    chk("single_pndng", 32'(pndng_o), 32'd1);
    chk("single_data", data_out_o, 32'hA5A5_0002);
    chk("single_gid", 32'(grant_id_o), 32'd2);

    // Restart from reset, then stream with all four pending.
    rst_i = 1'b0;
    step();
    rst_i = 1'b1; req_pndng_i = 4'b1111; popin_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      logic [NR-1:0] want;
      want = NR'(1) << (c % 4);
      #1 chk("rr_pop", 32'(req_pop_o), 32'(want));
      step();
      chk("rr_pndng", 32'(pndng_o), 32'd1);
    end
    chk("rr_cnt4", 32'(sent_cnt_o), 32'd4);
    chk("rr_gid0", 32'(grant_id_o), 32'd0);

    // Backpressure: nothing moves for 20 cycles.
    popin_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1 chk("bp_pop", 32'(req_pop_o), 32'd0);
      step();
    end
    chk("bp_data", data_out_o, 32'hA5A5_0000);
    chk("bp_gid", 32'(grant_id_o), 32'd0);
    chk("bp_cnt", 32'(sent_cnt_o), 32'd4);

    // Disabled: the held packet drains, then nothing is granted until enabled.
    en_i = 1'b0; popin_i = 1'b1;
    step();
    chk("dis_cnt", 32'(sent_cnt_o), 32'd5);
    chk("dis_pndng", 32'(pndng_o), 32'd0);
    popin_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("dis_pop", 32'(req_pop_o), 32'd0);
      step();
    end
    en_i = 1'b1;
    #1 chk("en_pop", 32'(req_pop_o), 32'h2);
    step();
    chk("en_gid", 32'(grant_id_o), 32'd1);

    // Reset while the router pops a held packet.
    popin_i = 1'b1; rst_i = 1'b0;
    #1 chk("rsthold_pop", 32'(req_pop_o), 32'd0);
    step();
    chk("rsthold_pndng", 32'(pndng_o), 32'd0);
    chk("rsthold_cnt", 32'(sent_cnt_o), 32'd0);
    rst_i = 1'b1;
    #1 chk("restart_pop", 32'(req_pop_o), 32'h1);
    step();
    chk("restart_gid", 32'(grant_id_o), 32'd0);

    // Counter wrap: 17 accepted packets on a 4-bit counter.
    for (int c = 0; c < 17; c++) step();
    chk("wrap_cnt", 32'(sent_cnt_o), 32'd1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst_i       = ($urandom_range(0, 99) != 0);
      en_i        = ($urandom_range(0, 7) != 0);
      popin_i     = ($urandom_range(0, 2) != 0);
      req_pndng_i = NR'($urandom);
      for (int k = 0; k < int'(NR); k++) req_data_i[k*PW +: PW] = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mesh_port_arbiter.md
MESH_PORT_ARBITER -- requirements
Module: mesh_port_arbiter

Interface
REQ-001 Parameter PAKG_SIZE, default 32: packet width in bits, equal to the mesh router terminal packet width.
REQ-002 Parameter NUM_REQ, default 4: number of local requesters sharing one mesh terminal input port; legal range 1..16.
REQ-003 Parameter CNT_W, default 16: width of the sent-packet counter.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-low.
REQ-006 en_i  input  1  grant enable; 0 blocks new grants.
REQ-007 req_pndng_i  input  NUM_REQ  per-requester FIFO-style pending flag; requester k has a valid head packet while bit k = 1.
REQ-008 req_data_i  input  NUM_REQ*PAKG_SIZE  head packets; requester k occupies bits [k*PAKG_SIZE +: PAKG_SIZE].
REQ-009 req_pop_o  output  NUM_REQ  one-cycle pop pulse to requester k; the requester advances its head on that edge.
REQ-010 pndng_o  output  1  packet pending toward router terminal input (drives pndng_i_in).
REQ-011 data_out_o  output  PAKG_SIZE  packet toward router (drives data_out_i_in).
REQ-012 popin_i  input  1  router pop of the presented packet (from popin).
REQ-013 grant_id_o  output  max(1,$clog2(NUM_REQ))  index of requester whose packet is presented.
REQ-014 sent_cnt_o  output  CNT_W  count of packets accepted by the router.

Function
REQ-015 States: IDLE (pndng_o=0) and HOLD (pndng_o=1); no other states.
REQ-016 Selection: requester chosen is the first k with req_pndng_i[k]=1 searching from rr_ptr upward, wrapping modulo NUM_REQ.
REQ-017 IDLE, en_i=1, any req_pndng_i set: req_pop_o[k] asserted combinationally that cycle for the selected k only; on the edge data_out_o<=packet k, grant_id_o<=k, rr_ptr<=(k+1) mod NUM_REQ, go HOLD.
REQ-018 Latency from req_pndng_i rising (in IDLE, en_i=1) to pndng_o=1: exactly one clock.
REQ-019 HOLD: data_out_o and grant_id_o held stable until popin_i=1 is sampled.
REQ-020 HOLD with popin_i=1: sent_cnt_o increments by 1 on that edge, wrapping from 2^CNT_W-1 to 0.
REQ-021 HOLD with popin_i=1, en_i=1 and a pending request: pop and reload per REQ-016/017 on the same edge, stay HOLD; pndng_o stays 1 (zero-bubble back-to-back).
REQ-022 HOLD with popin_i=1 and no eligible request (or en_i=0): go IDLE, pndng_o=0 next cycle.
REQ-023 popin_i in IDLE is ignored: no counter change, no state change.
REQ-024 en_i=0 never aborts a held packet; it is presented until popped.
REQ-025 req_pop_o is zero in every cycle except a grant cycle; at most one bit set; never set for a requester with req_pndng_i bit 0.
REQ-026 Same requester may be granted consecutively only when no other requester is pending.
REQ-027 NUM_REQ=1: rr_ptr constant 0; behaviour otherwise identical.

Reset
REQ-028 rst_i=0 sampled at a rising edge forces: state IDLE, pndng_o=0, data_out_o=0, grant_id_o=0, rr_ptr=0, sent_cnt_o=0; req_pop_o=0 during any cycle with rst_i=0.
REQ-029 Reset dominates popin_i and en_i; a packet held in HOLD at reset is discarded, not re-requested, and not counted.
REQ-030 First grant possible in the first cycle with rst_i=1.

Verification
REQ-031 Single request: reset, en_i=1, req_pndng_i=4'b0100, data2=32'hA5A5_0002 -> req_pop_o=4'b0100 one cycle, next cycle pndng_o=1, data_out_o=32'hA5A5_0002, grant_id_o=2.
REQ-032 All four pending continuously, popin_i=1 every cycle in HOLD -> grants 0,1,2,3,0 in consecutive cycles, pndng_o never drops, sent_cnt_o=4 after the fourth pop.
REQ-033 Backpressure: HOLD with popin_i=0 for 20 cycles -> data_out_o and grant_id_o unchanged, req_pop_o=0 throughout, sent_cnt_o unchanged.
REQ-034 en_i=0 in HOLD with requests pending: popin_i pulse -> sent_cnt_o+1, IDLE, no req_pop_o until en_i=1.
REQ-035 Counter wrap (CNT_W=4): 17 accepted packets -> sent_cnt_o=1.
REQ-036 rst_i=0 while in HOLD with popin_i=1 -> next cycle pndng_o=0, sent_cnt_o=0, no pop pulse; after release, grant restarts from requester 0.
